xif_offload: RTL and testbench
==============================

XIF_OFFLOAD -- requirements
Module: xif_offload

Interface
REQ-001 SHALL have parameter XLEN, 32, integer register and operand width.
REQ-002 SHALL have parameter X_NUM_RS, 3, number of source operands forwarded.
REQ-003 SHALL have parameter X_ID_WIDTH, 4, transaction ID width; ID space is 2^X_ID_WIDTH.
REQ-004 SHALL have ports ck in 1 (clock) and rst_n in 1 (reset); one clock, reset asynchronous and active-low.
REQ-005 SHALL have core offload ports off_valid in 1, off_ready out 1, off_instr in 32, off_rs in X_NUM_RS*XLEN, off_rs_valid in X_NUM_RS, off_kill in 1 (speculation failed for the offered instruction).
REQ-006 SHALL have off_reject out 1: one-cycle pulse, instruction not accepted (core raises illegal-instruction).
REQ-007 SHALL have XIF issue ports issue_valid out 1, issue_ready in 1, issue_req out (instr, id, rs, rs_valid), issue_resp in (accept, writeback, loadstore).
REQ-008 SHALL have XIF commit ports commit_valid out 1, commit out (id, commit_kill).
REQ-009 SHALL have XIF result ports result_valid in 1, result_ready out 1, result in (id, data XLEN, rd 5, we 1).
REQ-010 SHALL have core writeback ports wb_valid out 1, wb_ready in 1, wb_id out X_ID_WIDTH, wb_rd out 5, wb_data out XLEN.
REQ-011 SHALL have proto_err out 1: sticky protocol-error flag.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, COMMIT; reset state IDLE.
REQ-013 IDLE->ISSUE when off_valid and tracker bit for next_id is clear; off_ready=1 for exactly that cycle (operands, instr, next_id captured into issue_req).
REQ-014 ISSUE: issue_valid=1, issue_req held stable until issue_valid&&issue_ready; then ->COMMIT.
REQ-015 On issue handshake with accept=1 and (writeback|loadstore)=1, SHALL set tracker bit [id]; with accept=0, SHALL pulse off_reject in the handshake cycle.
REQ-016 COMMIT: commit_valid=1 for exactly one cycle, commit.id=issued id, commit_kill = off_kill sampled that cycle OR accept was 0; then ->IDLE; next_id increments modulo 2^X_ID_WIDTH.
REQ-017 Commit with commit_kill=1 SHALL clear tracker bit [id] in the same edge.
REQ-018 Issue-to-commit latency SHALL be exactly 1 cycle after the issue handshake; minimum offload spacing 3 cycles.
REQ-019 If tracker bit [next_id] is set (ID wrap onto outstanding), SHALL stay in IDLE with off_ready=0 until cleared.
REQ-020 result_ready = !wb_valid || wb_ready (one-entry output register).
REQ-021 On result handshake SHALL load wb_* from result next edge (latency 1), set wb_valid=result.we, clear tracker bit [result.id].
REQ-022 wb_valid SHALL hold with stable wb_* until wb_ready; simultaneous drain and new result SHALL overwrite without bubble.
REQ-023 Result with tracker bit [id] clear SHALL set proto_err and be dropped (wb_valid unchanged).
REQ-024 Simultaneous set and clear of the same tracker bit SHALL resolve as set (new issue wins).

Reset
REQ-025 rst_n low SHALL immediately force: FSM IDLE, off_ready=0, off_reject=0, issue_valid=0, commit_valid=0, result_ready=0 until first edge after release, wb_valid=0, wb_* data 0, next_id=0, tracker all 0, proto_err=0.
REQ-026 Reset mid-ISSUE or mid-COMMIT SHALL abandon the transaction with no commit emitted.

Structure
REQ-027 State enum and XIF issue/commit/result struct typedefs SHALL live in pa_rvfpm; no new package.
REQ-028 Tracker (2^X_ID_WIDTH bit vector, set/clear/query ports) SHALL be sub-module xif_id_tracker.

Verification
REQ-029 fadd.s offered, issue_ready=1, accept=1 writeback=1 -> commit id=0 kill=0 one cycle after handshake; result data=0x40400000 rd=5 -> wb_valid next cycle with same.
REQ-030 issue_ready held 0 for 4 cycles -> issue_req stable, single handshake, single commit.
REQ-031 accept=0 -> off_reject pulse, commit_kill=1, no tracker bit, later result with that id -> proto_err=1.
REQ-032 off_kill=1 in COMMIT -> commit_kill=1, tracker bit cleared, next offload proceeds.
REQ-033 16 accepted, no results -> 17th offload stalls off_ready=0; result id=0 -> stall released, id=0 reused.
REQ-034 wb_ready=0 with wb_valid=1 -> result_ready=0; assert rst_n low mid-ISSUE -> all outputs zero asynchronously.

Source files
------------

// File: rtl/pa_rvfpm.sv
// pa_rvfpm: shared XIF offload types, widths and the FSM state enum.
package pa_rvfpm;
  localparam int XIF_XLEN = 32;
  localparam int XIF_NUM_RS = 3;
  localparam int XIF_ID_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} xif_state_e;
  typedef struct packed {
    logic [31:0] instr;
    logic [XIF_ID_WIDTH-1:0] id;
    logic [XIF_NUM_RS*XIF_XLEN-1:0] rs;
    logic [XIF_NUM_RS-1:0] rs_valid;
  } x_issue_req_t;
  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
  } x_issue_resp_t;
  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic commit_kill;
  } x_commit_t;
  typedef struct packed {
    logic [XIF_ID_WIDTH-1:0] id;
    logic [XIF_XLEN-1:0] data;
    logic [4:0] rd;
    logic we;
  } x_result_t;
  // An accepted instruction only owes a result when it writes back or touches memory.
  function automatic logic needs_track(x_issue_resp_t r);
    return r.accept && (r.writeback || r.loadstore);
  endfunction
endpackage

// File: rtl/xif_offload_if.sv
// xif_offload_if: core offload, XIF issue/commit/result and writeback signals.
interface xif_offload_if import pa_rvfpm::*; #(
  parameter int XLEN = XIF_XLEN,
  parameter int X_NUM_RS = XIF_NUM_RS,
  parameter int X_ID_WIDTH = XIF_ID_WIDTH
) ();
  logic off_valid;
  logic off_ready;
  logic [31:0] off_instr;
  logic [X_NUM_RS*XLEN-1:0] off_rs;
  logic [X_NUM_RS-1:0] off_rs_valid;
  logic off_kill;
  logic off_reject;
  logic issue_valid;
  logic issue_ready;
  x_issue_req_t issue_req;
  x_issue_resp_t issue_resp;
  logic commit_valid;
  x_commit_t commit;
  logic result_valid;
  logic result_ready;
  x_result_t result;
  logic wb_valid;
  logic wb_ready;
  logic [X_ID_WIDTH-1:0] wb_id;
  logic [4:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic proto_err;
  modport master (
    input off_valid, off_instr, off_rs, off_rs_valid, off_kill,
    input issue_ready, issue_resp, result_valid, result, wb_ready,
    output off_ready, off_reject, issue_valid, issue_req, commit_valid, commit,
    output result_ready, wb_valid, wb_id, wb_rd, wb_data, proto_err
  );
  modport slave (
    output off_valid, off_instr, off_rs, off_rs_valid, off_kill,
    output issue_ready, issue_resp, result_valid, result, wb_ready,
    input off_ready, off_reject, issue_valid, issue_req, commit_valid, commit,
    input result_ready, wb_valid, wb_id, wb_rd, wb_data, proto_err
  );
endinterface

// File: rtl/xif_id_tracker.sv
// xif_id_tracker: one outstanding bit per transaction ID with set/clear/query ports.
module xif_id_tracker #(
  parameter int ID_WIDTH = 4
) (
  input  logic ck,
  input  logic rst_n,
  input  logic set_en,
  input  logic [ID_WIDTH-1:0] set_id,
  input  logic clr_a_en,
  input  logic [ID_WIDTH-1:0] clr_a_id,
  input  logic clr_b_en,
  input  logic [ID_WIDTH-1:0] clr_b_id,
  input  logic [ID_WIDTH-1:0] query_a_id,
  input  logic [ID_WIDTH-1:0] query_b_id,
  output logic query_a,
  output logic query_b
);
  localparam int N = 1 << ID_WIDTH;
  logic [N-1:0] bits;
  logic [N-1:0] set_m;
  logic [N-1:0] clr_m;
  always_comb begin
    set_m = {{(N-1){1'b0}}, set_en} << set_id;
    clr_m = ({{(N-1){1'b0}}, clr_a_en} << clr_a_id) | ({{(N-1){1'b0}}, clr_b_en} << clr_b_id);
  end
  // Set is applied after clear so a new issue wins a same-edge collision.
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) bits <= '0;
    else bits <= (bits & ~clr_m) | set_m;
  assign query_a = bits[query_a_id];
  assign query_b = bits[query_b_id];
endmodule

// File: rtl/xif_offload.sv
// xif_offload: bridges core offloads onto XIF issue/commit and returns results as writebacks.
module xif_offload import pa_rvfpm::*; #(
  parameter int XLEN = XIF_XLEN,
  parameter int X_NUM_RS = XIF_NUM_RS,
  parameter int X_ID_WIDTH = XIF_ID_WIDTH
) (
  input logic ck,
  input logic rst_n,
  xif_offload_if.master bus
);
  xif_state_e state;
  logic alive;
  logic [X_ID_WIDTH-1:0] next_id;
  logic [31:0] instr_q;
  logic [X_NUM_RS*XLEN-1:0] rs_q;
  logic [X_NUM_RS-1:0] rsv_q;
  logic accept_q;
  logic wb_valid_q;
  logic [X_ID_WIDTH-1:0] wb_id_q;
  logic [4:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic proto_err_q;
  logic busy_next;
  logic res_tracked;
  logic issue_hs;
  logic res_hs;
  logic commit_kill;
  // alive holds ready outputs low until the first edge after reset release.
  assign bus.off_ready = alive && state == IDLE && bus.off_valid && !busy_next;
  assign bus.issue_valid = state == ISSUE;
  assign bus.commit_valid = state == COMMIT;
  assign bus.result_ready = alive && (!wb_valid_q || bus.wb_ready);
  assign issue_hs = state == ISSUE && bus.issue_ready;
  assign res_hs = bus.result_valid && bus.result_ready;
  assign commit_kill = bus.off_kill || !accept_q;
  assign bus.off_reject = issue_hs && !bus.issue_resp.accept;
  assign bus.issue_req = {instr_q, next_id, rs_q, rsv_q};
  assign bus.commit = {next_id, commit_kill};
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_id = wb_id_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_data = wb_data_q;
  assign bus.proto_err = proto_err_q;
  xif_id_tracker #(.ID_WIDTH(X_ID_WIDTH)) u_tracker (
    .ck(ck),
    .rst_n(rst_n),
    .set_en(issue_hs && needs_track(bus.issue_resp)),
    .set_id(next_id),
    .clr_a_en(state == COMMIT && commit_kill),
    .clr_a_id(next_id),
    .clr_b_en(res_hs && res_tracked),
    .clr_b_id(bus.result.id),
    .query_a_id(next_id),
    .query_b_id(bus.result.id),
    .query_a(busy_next),
    .query_b(res_tracked)
  );
  // The in-flight ID is next_id itself; it only advances once the commit is sent.
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
      next_id <= '0;
      instr_q <= '0;
      rs_q <= '0;
      rsv_q <= '0;
      accept_q <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        IDLE: if (bus.off_ready) begin
          state <= ISSUE;
          instr_q <= bus.off_instr;
          rs_q <= bus.off_rs;
          rsv_q <= bus.off_rs_valid;
        end
        ISSUE: if (bus.issue_ready) begin
          state <= COMMIT;
          accept_q <= bus.issue_resp.accept;
        end
        COMMIT: begin
          state <= IDLE;
          next_id <= next_id + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  // Untracked results are dropped and flagged; a pending drain still completes.
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_id_q <= '0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (res_hs && !res_tracked) proto_err_q <= 1'b1;
      if (res_hs && res_tracked) begin
        wb_valid_q <= bus.result.we;
        wb_id_q <= bus.result.id;
        wb_rd_q <= bus.result.rd;
        wb_data_q <= bus.result.data;
      end else if (bus.wb_ready) wb_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_xif_offload.sv
// tb_xif_offload: randomized bench with a transaction-level model and scoreboard queues.
module tb_xif_offload;
  import pa_rvfpm::*;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 ck = ~ck;
  xif_offload_if xif();
  xif_offload dut (.ck(ck), .rst_n(rst_n), .bus(xif));
  int total = 0;
  int bad = 0;
  int off_pct = 100, ir_pct = 0, acc_pct = 0, wbk_pct = 0, kill_pct = 0, res_pct = 0, wbr_pct = 0;
  bit fix_en = 1'b1;
  logic [3:0] fix_id = 4'd0;
  logic [31:0] fix_data = 32'h0;
  logic [4:0] fix_rd = 5'd0;
  // reference model: outstanding set, ID counter, transaction phase, expectation queues
  bit outst[16];
  int nid = 0;
  int phase = 0;
  bit alive_m = 1'b0;
  bit perr = 1'b0;
  bit cur_acc;
  x_issue_req_t cur_req;
  x_issue_req_t exp_iss[$];
  x_result_t exp_wb[$];
  int cand[$];
  int n_off = 0, n_iss = 0, n_com = 0, n_kill = 0, n_rej = 0, n_res = 0, n_wb = 0;
  logic [3:0] last_iss_id = 4'd0;
  logic [31:0] last_wb_data = 32'h0;
  task automatic chk(string n, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic bit roll(int p);
    return int'($urandom_range(99)) < p;
  endfunction
  function automatic int n_outst();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(outst[i]);
    return c;
  endfunction
  function automatic int cnt(int w);
    return w == 0 ? n_off : w == 1 ? n_iss : w == 2 ? n_com : n_res;
  endfunction
  task automatic step(int n);
    repeat (n) @(negedge ck);
    #1;
  endtask
  task automatic wait_cnt(string nm, int w, int tgt);
    for (int i = 0; i < 400 && cnt(w) < tgt; i++) step(1);
    chk({nm, "_timeout"}, 128'(cnt(w) >= tgt), 128'(1));
  endtask
  task automatic wait_drain(string nm);
    for (int i = 0; i < 600 && (n_outst() != 0 || exp_wb.size() != 0); i++) step(1);
    chk({nm, "_drain"}, 128'(n_outst()), 128'(0));
  endtask
  task automatic chk_zero(string nm);
    chk({nm, "_off_ready"}, xif.off_ready, 0);
    chk({nm, "_off_reject"}, xif.off_reject, 0);
    chk({nm, "_issue_valid"}, xif.issue_valid, 0);
    chk({nm, "_commit_valid"}, xif.commit_valid, 0);
    chk({nm, "_result_ready"}, xif.result_ready, 0);
    chk({nm, "_wb_valid"}, xif.wb_valid, 0);
    chk({nm, "_wb_id"}, xif.wb_id, 0);
    chk({nm, "_wb_rd"}, xif.wb_rd, 0);
    chk({nm, "_wb_data"}, xif.wb_data, 0);
    chk({nm, "_proto_err"}, xif.proto_err, 0);
  endtask
  initial forever begin
    @(posedge ck or negedge rst_n);
    alive_m = rst_n;
  end
  // driver
  initial begin
    xif.off_valid = 0; xif.off_instr = 0; xif.off_rs = 0; xif.off_rs_valid = 0; xif.off_kill = 0;
    xif.issue_ready = 0; xif.issue_resp = '0; xif.result_valid = 0; xif.result = '0; xif.wb_ready = 0;
    forever begin
      @(posedge ck);
      #1;
      xif.off_valid = roll(off_pct);
      xif.off_instr = $urandom;
      xif.off_rs = {$urandom, $urandom, $urandom};
      xif.off_rs_valid = 3'($urandom);
      xif.off_kill = roll(kill_pct);
      xif.issue_ready = roll(ir_pct);
      xif.issue_resp = '{accept: roll(acc_pct), writeback: roll(wbk_pct), loadstore: roll(10)};
      xif.wb_ready = roll(wbr_pct);
      cand.delete();
      for (int i = 0; i < 16; i++) if (outst[i]) cand.push_back(i);
      if (fix_en) begin
        xif.result_valid = 1'b1;
        xif.result = '{id: fix_id, data: fix_data, rd: fix_rd, we: 1'b1};
      end else if (cand.size() > 0 && roll(res_pct)) begin
        xif.result_valid = 1'b1;
        xif.result = '{id: 4'(cand[$urandom_range(cand.size() - 1)]), data: $urandom, rd: 5'($urandom), we: roll(85)};
      end else xif.result_valid = 1'b0;
    end
  end
  // monitor / scoreboard
  initial forever begin
    bit e_ordy, ihs, wbv, rhs, kill;
    x_issue_req_t r;
    @(negedge ck);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) outst[i] = 1'b0;
      nid = 0; phase = 0; perr = 1'b0;
      exp_iss.delete(); exp_wb.delete();
      continue;
    end
    e_ordy = alive_m && xif.off_valid && phase == 0 && !outst[nid];
    ihs = phase == 1 && xif.issue_ready;
    wbv = exp_wb.size() > 0;
    kill = xif.off_kill || !cur_acc;
    chk("off_ready", xif.off_ready, e_ordy);
    chk("issue_valid", xif.issue_valid, phase == 1);
    if (phase == 1 && exp_iss.size() > 0) begin
      chk("issue_instr", xif.issue_req.instr, exp_iss[0].instr);
      chk("issue_id", xif.issue_req.id, exp_iss[0].id);
      chk("issue_rs", xif.issue_req.rs, exp_iss[0].rs);
      chk("issue_rs_valid", xif.issue_req.rs_valid, exp_iss[0].rs_valid);
    end
    chk("off_reject", xif.off_reject, ihs && !xif.issue_resp.accept);
    chk("commit_valid", xif.commit_valid, phase == 2);
    if (phase == 2) begin
      chk("commit_id", xif.commit.id, cur_req.id);
      chk("commit_kill", xif.commit.commit_kill, kill);
    end
    chk("result_ready", xif.result_ready, alive_m && (!wbv || xif.wb_ready));
    chk("wb_valid", xif.wb_valid, wbv);
    if (wbv) begin
      chk("wb_id", xif.wb_id, exp_wb[0].id);
      chk("wb_rd", xif.wb_rd, exp_wb[0].rd);
      chk("wb_data", xif.wb_data, exp_wb[0].data);
    end
    chk("proto_err", xif.proto_err, perr);
    rhs = xif.result_valid && alive_m && (!wbv || xif.wb_ready);
    if (wbv && xif.wb_ready) begin
      n_wb++;
      last_wb_data = xif.wb_data;
      void'(exp_wb.pop_front());
    end
    if (rhs) begin
      n_res++;
      if (outst[xif.result.id]) begin
        if (xif.result.we) exp_wb.push_back(xif.result);
        outst[xif.result.id] = 1'b0;
      end else perr = 1'b1;
    end
    if (phase == 2) begin
      n_com++;
      if (kill) begin
        n_kill++;
        outst[cur_req.id] = 1'b0;
      end
      nid = (nid + 1) % 16;
      phase = 0;
    end else if (ihs) begin
      n_iss++;
      last_iss_id = xif.issue_req.id;
      cur_req = exp_iss.pop_front();
      cur_acc = xif.issue_resp.accept;
      if (!cur_acc) n_rej++;
      if (cur_acc && (xif.issue_resp.writeback || xif.issue_resp.loadstore)) outst[cur_req.id] = 1'b1;
      phase = 2;
    end else if (e_ordy) begin
      n_off++;
      r = '{instr: xif.off_instr, id: 4'(nid), rs: xif.off_rs, rs_valid: xif.off_rs_valid};
      exp_iss.push_back(r);
      phase = 1;
    end
  end
  // directed sequence followed by a random soak
  initial begin
    int base, rb;
    #3;
    chk_zero("rst0");
    step(2);
    chk_zero("rst1");
    off_pct = 100; fix_en = 1'b0; wbr_pct = 100; ir_pct = 100; acc_pct = 100; wbk_pct = 100;
    @(negedge ck);
    #2 rst_n = 1'b1;
    #1;
    chk("rel_off_ready", xif.off_ready, 0);
    chk("rel_result_ready", xif.result_ready, 0);
    wait_cnt("s1_off", 0, 1);
    off_pct = 0;
    wait_cnt("s1_com", 2, 1);
    chk("s1_id", last_iss_id, 0);
    chk("s1_rej", n_rej, 0);
    chk("s1_kill", n_kill, 0);
    step(2);
    fix_en = 1'b1; fix_id = 4'd0; fix_data = 32'h40400000; fix_rd = 5'd5;
    wait_cnt("s1_res", 3, 1);
    fix_en = 1'b0;
    step(3);
    chk("s1_wb_cnt", n_wb, 1);
    chk("s1_wb_data", last_wb_data, 32'h40400000);
    ir_pct = 0; off_pct = 100;
    wait_cnt("s2_off", 0, 2);
    off_pct = 0;
    step(4);
    chk("s2_held", n_iss, 1);
    chk("s2_valid", xif.issue_valid, 1);
    ir_pct = 100;
    wait_cnt("s2_com", 2, 2);
    step(3);
    chk("s2_iss", n_iss, 2);
    chk("s2_com_once", n_com, 2);
    chk("s2_id", last_iss_id, 1);
    kill_pct = 100; off_pct = 100;
    wait_cnt("s3_off", 0, 3);
    off_pct = 0;
    wait_cnt("s3_com", 2, 3);
    kill_pct = 0;
    chk("s3_kill", n_kill, 1);
    off_pct = 100;
    wait_cnt("s3_next", 0, 4);
    off_pct = 0;
    wait_cnt("s3_com2", 2, 4);
    chk("s3_id", last_iss_id, 3);
    wbr_pct = 0; fix_en = 1'b1; fix_id = 4'd1; fix_data = 32'hcafe0001; fix_rd = 5'd9;
    wait_cnt("s5_res", 3, 2);
    fix_en = 1'b0;
    step(2);
    chk("s5_wb_hold", xif.wb_valid, 1);
    chk("s5_rr_low", xif.result_ready, 0);
    ir_pct = 0; off_pct = 100;
    wait_cnt("s5_off", 0, 5);
    step(2);
    chk("s5_in_issue", xif.issue_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("s5");
    off_pct = 0; ir_pct = 100; wbr_pct = 100;
    step(2);
    #2 rst_n = 1'b1;
    step(4);
    chk("s5_no_commit", n_com, 4);
    base = n_com;
    off_pct = 100; res_pct = 0;
    wait_cnt("s4_fill", 2, base + 16);
    step(10);
    chk("s4_stall", n_com, base + 16);
    chk("s4_off_ready", xif.off_ready, 0);
    rb = n_res;
    fix_en = 1'b1; fix_id = 4'd0; fix_data = $urandom; fix_rd = 5'd3;
    wait_cnt("s4_res", 3, rb + 1);
    fix_en = 1'b0;
    wait_cnt("s4_reuse", 2, base + 17);
    chk("s4_id0", last_iss_id, 0);
    off_pct = 0; res_pct = 100;
    wait_drain("s4");
    off_pct = 60; ir_pct = 70; acc_pct = 80; wbk_pct = 70; kill_pct = 20; res_pct = 40; wbr_pct = 60;
    step(2000);
    off_pct = 0; kill_pct = 0; res_pct = 100; wbr_pct = 100;
    step(4);
    wait_drain("rnd");
    step(3);
    acc_pct = 0; rb = n_rej; base = n_com;
    off_pct = 100;
    wait_cnt("s7_off", 2, base + 1);
    off_pct = 0;
    chk("s7_rej", n_rej, rb + 1);
    chk("s7_perr0", xif.proto_err, 0);
    rb = n_wb;
    fix_en = 1'b1; fix_id = last_iss_id; fix_data = 32'hdeadbeef; fix_rd = 5'd7;
    wait_cnt("s7_res", 3, n_res + 1);
    fix_en = 1'b0;
    step(3);
    chk("s7_perr1", xif.proto_err, 1);
    chk("s7_no_wb", n_wb, rb);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
